// File: rtl/full_subtractor_using_half.sv
// Registered ripple-borrow full subtractor built from half-subtractor cells.
// Optional input register stage enabled by defining FS_INPUT_REG_EN.

module half_subtractor (
  input  logic x,
  input  logic y,
  output logic diff,
  output logic borrow
);

  assign diff   = x ^ y;
  assign borrow = ~x & y;

endmodule

module full_subtractor_using_half #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  logic [WIDTH-1:0] a_c;
  logic [WIDTH-1:0] b_c;
  logic             bin_c;

`ifdef FS_INPUT_REG_EN
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             bin_q;

  // Input capture stage ahead of the subtractor core
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      bin_q <= 1'b0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      bin_q <= bin;
    end
  end

  assign a_c   = a_q;
  assign b_c   = b_q;
  assign bin_c = bin_q;
`else
  assign a_c   = a;
  assign b_c   = b;
  assign bin_c = bin;
`endif

  logic [WIDTH:0]   borrow_c;
  logic [WIDTH-1:0] d1_c;
  logic [WIDTH-1:0] br1_c;
  logic [WIDTH-1:0] br2_c;
  logic [WIDTH-1:0] diff_c;

  assign borrow_c[0] = bin_c;

  // Per bit: HS1 on the operands, HS2 folds in the incoming borrow
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    half_subtractor u_hs1 (
      .x      (a_c[i]),
      .y      (b_c[i]),
      .diff   (d1_c[i]),
      .borrow (br1_c[i])
    );

    half_subtractor u_hs2 (
      .x      (d1_c[i]),
      .y      (borrow_c[i]),
      .diff   (diff_c[i]),
      .borrow (br2_c[i])
    );

    assign borrow_c[i+1] = br1_c[i] | br2_c[i];
  end

  // Output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d    <= '0;
      bout <= 1'b0;
    end else begin
      d    <= diff_c;
      bout <= borrow_c[WIDTH];
    end
  end

endmodule

// File: tb/tb_full_subtractor_using_half.sv
// Scoreboard bench for full_subtractor_using_half at WIDTH=1 and WIDTH=4.
// Expected latency follows FS_INPUT_REG_EN.

module tb_full_subtractor_using_half;

`ifdef FS_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int       due;
    logic [3:0] d;
    logic     bout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:0] a1 = '0, b1 = '0;
  logic       bin1 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       bin4 = 1'b0;
  logic [0:0] d1;
  logic       bout1;
  logic [3:0] d4;
  logic       bout4;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  exp_t q1[$];
  exp_t q4[$];

  full_subtractor_using_half #(.WIDTH(1)) u_dut1 (
    .clk (clk), .rst (rst), .a (a1), .b (b1), .bin (bin1), .d (d1), .bout (bout1)
  );

  full_subtractor_using_half #(.WIDTH(4)) u_dut4 (
    .clk (clk), .rst (rst), .a (a4), .b (b4), .bin (bin4), .d (d4), .bout (bout4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {bout,d}=%b expected %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  function automatic exp_t model(input int a, input int b, input int bin, input int w);
    exp_t e;
    int r;
    r = a - b - bin;
    e.d    = 4'(r & ((1 << w) - 1));
    e.bout = (a < b + bin);
    e.due  = 0;
    return e;
  endfunction

  task automatic push1(input exp_t e);
    e.due = cyc + LAT;
    q1.push_back(e);
  endtask

  task automatic push4(input exp_t e);
    e.due = cyc + LAT;
    q4.push_back(e);
  endtask

  task automatic issue4(input int a, input int b, input int bin, input int ed, input int eb);
    exp_t e;
    @(negedge clk);
    a4 = 4'(a); b4 = 4'(b); bin4 = 1'(bin);
    e.d = 4'(ed); e.bout = 1'(eb); e.due = 0;
    push4(e);
  endtask

  // Monitor: compare each result on the cycle it becomes due
  always @(negedge clk) begin
    if (!rst) begin
      while (q1.size() != 0 && q1[0].due <= cyc) begin
        if (q1[0].due < cyc) begin
          errors++; checks++;
          $display("FAIL w1_missed: result due at cycle %0d not seen, now %0d", q1[0].due, cyc);
        end else
          check("w1_result", {bout1, 4'(d1)}, {q1[0].bout, q1[0].d});
        void'(q1.pop_front());
      end
      while (q4.size() != 0 && q4[0].due <= cyc) begin
        if (q4[0].due < cyc) begin
          errors++; checks++;
          $display("FAIL w4_missed: result due at cycle %0d not seen, now %0d", q4[0].due, cyc);
        end else
          check("w4_result", {bout4, d4}, {q4[0].bout, q4[0].d});
        void'(q4.pop_front());
      end
    end
  end

  task automatic drain;
    repeat (LAT + 2) @(negedge clk);
    if (q1.size() != 0 || q4.size() != 0) begin
      errors++; checks++;
      $display("FAIL drain: %0d/%0d results outstanding, expected 0/0", q1.size(), q4.size());
      q1.delete(); q4.delete();
    end
  endtask

  logic [1:0] sw_exp [8];

  initial begin
    exp_t e;
    int ra, rb, rc;
    // {d,bout} per (a,b,bin) from the truth table
    sw_exp[0] = 2'b00; sw_exp[1] = 2'b11; sw_exp[2] = 2'b11; sw_exp[3] = 2'b01;
    sw_exp[4] = 2'b10; sw_exp[5] = 2'b00; sw_exp[6] = 2'b00; sw_exp[7] = 2'b11;

    a1 = 1'b1; a4 = 4'd9; b4 = 4'd2;
    #1;
    check("reset_w1", {bout1, 4'(d1)}, 5'd0);
    check("reset_w4", {bout4, d4}, 5'd0);
    repeat (2) @(negedge clk);
    check("reset_hold_w4", {bout4, d4}, 5'd0);
    rst = 1'b0;

    // Exhaustive WIDTH=1 sweep
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); bin1 = 1'(i);
      e.d = 4'(sw_exp[i][1]); e.bout = sw_exp[i][0]; e.due = 0;
      push1(e);
    end
    drain();

    // Directed WIDTH=4 vectors and boundaries
    issue4(9, 4, 0, 5, 0);
    issue4(3, 5, 1, 13, 1);
    issue4(0, 0, 1, 15, 1);
    issue4(15, 15, 0, 0, 0);
    issue4(15, 0, 0, 15, 0);
    issue4(0, 15, 1, 0, 1);
    drain();

    // Back-to-back random traffic on both instances
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      ra = int'($urandom_range(0, 15)); rb = int'($urandom_range(0, 15)); rc = int'($urandom_range(0, 1));
      a4 = 4'(ra); b4 = 4'(rb); bin4 = 1'(rc);
      push4(model(ra, rb, rc, 4));
      ra = int'($urandom_range(0, 1)); rb = int'($urandom_range(0, 1)); rc = int'($urandom_range(0, 1));
      a1 = 1'(ra); b1 = 1'(rb); bin1 = 1'(rc);
      push1(model(ra, rb, rc, 1));
    end
    drain();

    // Asynchronous reset mid-cycle with a nonzero result on the outputs
    issue4(5, 2, 0, 3, 0);
    drain();
    @(posedge clk);
    #2;
    check("pre_async_w4", {bout4, d4}, 5'd3);
    rst = 1'b1;
    q1.delete(); q4.delete();
    #1;
    check("async_rst_w4", {bout4, d4}, 5'd0);
    check("async_rst_w1", {bout1, 4'(d1)}, 5'd0);

    // Reset held across edges with a=1,b=0,bin=0, then released between edges
    a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
    a4 = 4'd1; b4 = 4'd0; bin4 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_w4", {bout4, d4}, 5'd0);
      check("rst_hold_w1", {bout1, 4'(d1)}, 5'd0);
    end
    rst = 1'b0;
    e.d = 4'd1; e.bout = 1'b0; e.due = 0;
    push1(e);
    push4(e);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
